// File: rtl/data_mem.sv
// rtl/data_mem.sv - single-cycle data memory with byte-lane stores, sticky fault capture and optional MMIO window (DATA_MEM_MMIO_EN)
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic [1:0]  MemWrite,
    output logic [31:0] rdata,
    output logic        fault
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          in_range;
    logic          mmio_hit;
    logic          oor;
    logic          is_store;
    logic          misaligned;
    logic          store_ok;
    logic          ram_sel;
    logic          ram_we;
    logic [4:0]    sh;
    logic [3:0]    be_base;
    logic [3:0]    be;
    logic [31:0]   wshift;
    logic [1:0]    new_fault;
    logic          fault_clear;
    logic [31:0]   mmio_rdata;
    logic [1:0]    fault_status;
    logic [31:0]   fault_addr;

    assign idx      = addr[AW+1:2];
    assign in_range = {1'b0, addr} < RAM_BYTES;
    assign sh       = {addr[1:0], 3'b000};
    assign is_store = MemWrite != 2'b00;
    assign wshift   = wdata << sh;
    assign be       = be_base << addr[1:0];

`ifdef DATA_MEM_MMIO_EN
    assign mmio_hit = addr[31:5] == MMIO_BASE[31:5];
    assign oor      = !in_range && !mmio_hit;
`else
    // Without the MMIO window its addresses are simply outside RAM.
    assign mmio_hit = 1'b0;
    assign oor      = !in_range || (addr[31:5] == MMIO_BASE[31:5]);
`endif

    // Store size decode: base lane mask and alignment check
    always_comb begin
        be_base    = 4'b0000;
        misaligned = 1'b0;
        case (MemWrite)
            2'b01: be_base = 4'b0001;
            2'b10: begin
                be_base    = 4'b0011;
                misaligned = addr[0];
            end
            2'b11: begin
                be_base    = 4'b1111;
                misaligned = addr[1:0] != 2'b00;
            end
            default: be_base = 4'b0000;
        endcase
    end

    assign store_ok  = is_store && !misaligned;
    assign ram_sel   = in_range && !mmio_hit && !oor;
    assign ram_we    = store_ok && ram_sel;
    assign new_fault = {(is_store || MemRead) && oor, is_store && misaligned};

    // RAM write: contents survive reset, but a store coinciding with rst is dropped
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

`ifdef DATA_MEM_MMIO_EN
    logic [63:0] cycle;
    logic [31:0] scratch;
    logic        scratch_we;

    assign fault_clear = store_ok && mmio_hit && addr[4:2] == 3'd2;
    assign scratch_we  = store_ok && mmio_hit && addr[4:2] == 3'd4;

    // Free-running cycle counter, wraps naturally at 2^64
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle <= 64'd0;
        else     cycle <= cycle + 64'd1;
    end

    // Scratch register, byte-enabled like RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch <= 32'd0;
        end else if (scratch_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) scratch[8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

    // MMIO register read mux, word-selected before the lane shift
    always_comb begin
        mmio_rdata = 32'd0;
        case (addr[4:2])
            3'd0:    mmio_rdata = cycle[31:0];
            3'd1:    mmio_rdata = cycle[63:32];
            3'd2:    mmio_rdata = {30'd0, fault_status};
            3'd3:    mmio_rdata = fault_addr;
            3'd4:    mmio_rdata = scratch;
            default: mmio_rdata = 32'd0;
        endcase
    end
`else
    assign fault_clear = 1'b0;
    assign mmio_rdata  = 32'd0;
`endif

    // Load path: right-aligned, zero when idle or when nothing is mapped
    always_comb begin
        rdata = 32'd0;
        if (MemRead) begin
            if (ram_sel)       rdata = mem[idx] >> sh;
            else if (mmio_hit) rdata = mmio_rdata >> sh;
        end
    end

    // Sticky fault capture: first fault wins until cleared or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_status <= 2'b00;
            fault_addr   <= 32'd0;
        end else if (fault_clear) begin
            fault_status <= 2'b00;
            fault_addr   <= 32'd0;
        end else if (fault_status == 2'b00 && new_fault != 2'b00) begin
            fault_status <= new_fault;
            fault_addr   <= addr;
        end
    end

    assign fault = fault_status != 2'b00;

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed self-checking bench for data_mem
module tb_data_mem;

    localparam logic [31:0] MB      = 32'hFFFF_0000;
    localparam logic [31:0] RAM_END = 32'h0001_0000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] rdata;
    logic        fault;

    int checks = 0;
    int errors = 0;

    data_mem dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .rdata    (rdata),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        addr     = a;
        wdata    = d;
        MemWrite = sz;
        MemRead  = 1'b0;
        @(posedge clk);
        #1;
        MemWrite = 2'b00;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        addr     = a;
        MemWrite = 2'b00;
        MemRead  = 1'b1;
        #1;
        v = rdata;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
    endtask

    task automatic read_status(output logic [31:0] s, output logic [31:0] a);
`ifdef DATA_MEM_MMIO_EN
        load(MB + 32'h08, s);
        load(MB + 32'h0C, a);
`else
        @(negedge clk);
        #1;
        s = {30'd0, dut.fault_status};
        a = dut.fault_addr;
`endif
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] s;
        logic [31:0] fa;

        rst      = 1'b1;
        addr     = 32'd0;
        wdata    = 32'd0;
        MemRead  = 1'b0;
        MemWrite = 2'b00;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_fault", {31'd0, fault}, 32'd0);
        chk("idle_rdata", rdata, 32'd0);

        @(negedge clk);
        rst = 1'b0;
`ifdef DATA_MEM_MMIO_EN
        addr    = MB;
        MemRead = 1'b1;
        #1;
        chk("cycle_first", rdata, 32'd0);
        repeat (10) @(negedge clk);
        #1;
        chk("cycle_10", rdata, 32'd10);
        addr = MB + 32'h04;
        #1;
        chk("cycle_hi_0", rdata, 32'd0);
        addr = MB + 32'h10;
        #1;
        chk("scratch_reset", rdata, 32'd0);
        MemRead = 1'b0;

        @(negedge clk);
        force dut.cycle = 64'h0000_0000_FFFF_FFFF;
        addr    = MB;
        MemRead = 1'b1;
        #1;
        chk("cycle_forced_lo", rdata, 32'hFFFF_FFFF);
        release dut.cycle;
        @(posedge clk);
        #1;
        addr = MB + 32'h04;
        #1;
        chk("cycle_wrap_hi", rdata, 32'd1);
        addr = MB;
        #1;
        chk("cycle_wrap_lo", rdata, 32'd0);
        MemRead = 1'b0;
`endif

        // Word store then shifted loads
        store(32'h100, 32'hDEAD_BEEF, 2'b11);
        load(32'h100, v); chk("word_load", v, 32'hDEAD_BEEF);
        load(32'h101, v); chk("load_off1", v, 32'h00DE_ADBE);
        load(32'h102, v); chk("load_off2", v, 32'h0000_DEAD);
        load(32'h103, v); chk("load_off3", v, 32'h0000_00DE);

        // Byte and halfword lane placement
        store(32'h100, 32'h1122_3344, 2'b11);
        store(32'h102, 32'h0000_00AA, 2'b01);
        load(32'h100, v); chk("byte_store", v, 32'h11AA_3344);
        store(32'h104, 32'h0000_0000, 2'b11);
        store(32'h106, 32'hFFFF_5566, 2'b10);
        load(32'h104, v); chk("half_store", v, 32'h5566_0000);
        load(32'h107, v); chk("half_byte3", v, 32'h0000_0055);
        chk("no_fault_yet", {31'd0, fault}, 32'd0);

        // Simultaneous load and store: read shows pre-write data
        @(negedge clk);
        addr     = 32'h100;
        wdata    = 32'hCAFE_F00D;
        MemWrite = 2'b11;
        MemRead  = 1'b1;
        #1;
        chk("rw_prewrite", rdata, 32'h11AA_3344);
        @(posedge clk);
        #1;
        MemWrite = 2'b00;
        MemRead  = 1'b0;
        load(32'h100, v); chk("rw_committed", v, 32'hCAFE_F00D);

        // Misaligned halfword store
        store(32'h103, 32'h0000_FFFF, 2'b10);
        chk("mis_fault_rise", {31'd0, fault}, 32'd1);
        load(32'h100, v); chk("mis_suppressed", v, 32'hCAFE_F00D);
        read_status(s, fa);
        chk("mis_status", s, 32'd1);
        chk("mis_addr", fa, 32'h103);

        // Later faults do not overwrite the first
        store(RAM_END, 32'h1234_5678, 2'b11);
        store(32'h102, 32'h1234_5678, 2'b11);
        load(32'h100, v); chk("mis_word_suppressed", v, 32'hCAFE_F00D);
        read_status(s, fa);
        chk("sticky_status", s, 32'd1);
        chk("sticky_addr", fa, 32'h103);

`ifdef DATA_MEM_MMIO_EN
        // Fault clear through MMIO
        store(MB + 32'h08, 32'd0, 2'b11);
        chk("clear_fault", {31'd0, fault}, 32'd0);
        read_status(s, fa);
        chk("clear_status", s, 32'd0);
        chk("clear_addr", fa, 32'd0);

        // Scratch with byte enables, reserved offsets
        store(MB + 32'h10, 32'h1234_5678, 2'b11);
        store(MB + 32'h11, 32'h0000_00AB, 2'b01);
        load(MB + 32'h10, v); chk("scratch_word", v, 32'h1234_AB78);
        load(MB + 32'h12, v); chk("scratch_shift", v, 32'h0000_1234);
        store(MB + 32'h18, 32'hFFFF_FFFF, 2'b11);
        load(MB + 32'h18, v); chk("reserved_read", v, 32'd0);
        chk("reserved_nofault", {31'd0, fault}, 32'd0);

        // Misaligned store to the clear register faults instead of clearing
        store(MB + 32'h09, 32'd0, 2'b10);
        read_status(s, fa);
        chk("mmio_mis_status", s, 32'd1);
        chk("mmio_mis_addr", fa, MB + 32'h09);
        store(MB + 32'h08, 32'd0, 2'b11);
        store(RAM_END, 32'd0, 2'b11);
`else
        load(MB, v); chk("mmio_absent_read", v, 32'd0);
`endif

        // Reset in the middle of a store
        store(32'h200, 32'h0000_0005, 2'b11);
        chk("pre_reset_fault", {31'd0, fault}, 32'd1);
        @(negedge clk);
        addr     = 32'h200;
        wdata    = 32'h0000_0099;
        MemWrite = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_fault", {31'd0, fault}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst      = 1'b0;
        MemWrite = 2'b00;
`ifdef DATA_MEM_MMIO_EN
        addr    = MB;
        MemRead = 1'b1;
        #1;
        chk("rst_cycle", rdata, 32'd0);
        MemRead = 1'b0;
        load(MB + 32'h10, v); chk("rst_scratch", v, 32'd0);
`endif
        load(32'h200, v); chk("rst_no_commit", v, 32'h0000_0005);
        read_status(s, fa);
        chk("rst_status", s, 32'd0);
        chk("rst_addr", fa, 32'd0);

        // Out-of-range load
        load(32'h0004_0000, v); chk("oor_load_rdata", v, 32'd0);
        chk("oor_load_fault", {31'd0, fault}, 32'd1);
        read_status(s, fa);
        chk("oor_status", s, 32'd2);
        chk("oor_addr", fa, 32'h0004_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
